spi_note_receiver: RTL and testbench
====================================

Name: spi_note_receiver

Overview:
SPI slave (mode 0) that receives note-event frames from the host MCU and converts them into the single-cycle note strobe and fields consumed by voice_controller (i_SPI_flag, i_SPI_note_status, i_SPI_voice_index, i_SPI_tuning_code, i_SPI_velocity). Sits directly upstream of voice_controller in the i_clk domain. SPI pins are asynchronous and oversampled; i_clk must be at least 8x SCK.

Parameters:
SYNC_STAGES, 2, flip-flop depth of the pin synchronizers (minimum 2).
VOICE_COUNT, 16, number of voices; any voice index >= VOICE_COUNT is rejected.
CMD_NOTE_ON, 8'h90, command byte for note on.
CMD_NOTE_OFF, 8'h80, command byte for note off.

Ports:
i_clk  in  1  system clock; sole clock domain.
i_reset  in  1  synchronous, active-high reset.
i_sck  in  1  SPI clock, asynchronous to i_clk, idle low.
i_mosi  in  1  SPI data, MSB first, sampled on SCK rising edge.
i_cs_n  in  1  SPI chip select, active low, asynchronous.
o_SPI_flag  out  1  one-cycle strobe; the fields below are valid in this cycle.
o_SPI_note_status  out  1  1 = note on, 0 = note off.
o_SPI_voice_index  out  8  target voice.
o_SPI_tuning_code  out  32  DDS phase increment.
o_SPI_velocity  out  8  note velocity; bit 7 always 0.
o_frame_error  out  1  one-cycle strobe on a rejected frame.

Behaviour:
- Reset: all outputs 0, FSM in IDLE, shift register and bit counter cleared. i_reset dominates every other event in the same cycle. Reset mid-frame abandons that frame; reception restarts only after i_cs_n is seen high, then low again.
- Synchronize i_sck, i_mosi and i_cs_n through SYNC_STAGES flip-flops. Register the synced SCK once more to detect rising edges (sck_rise) and the synced CS for fall and rise detection.
- Frame format: 7 bytes, 56 bits, MSB first.
  - byte0: command.
  - byte1: voice index.
  - bytes2-5: tuning code, MSB byte first.
  - byte6: velocity; only bits 6:0 are used.
- FSM states:
  - IDLE: on CS fall, clear the bit counter and go to RECEIVE.
  - RECEIVE: on each sck_rise, shift synced MOSI into the 56-bit shift register and increment a 6-bit counter. When the counter reaches 56, go to CHECK. If CS rises first (short frame), pulse o_frame_error and go to IDLE.
  - CHECK: lasts one cycle. Command must equal CMD_NOTE_ON or CMD_NOTE_OFF, and voice index must be < VOICE_COUNT.
    - Valid: register the fields into the outputs, assert o_SPI_flag for exactly 1 cycle, note_status = (command == CMD_NOTE_ON).
    - Invalid: pulse o_frame_error; the field outputs stay unchanged.
    - Either way, go to WAIT_CS.
  - WAIT_CS: ignore further SCK edges (extra bits are discarded without error). On CS rise, go to IDLE.
- Output fields hold their last valid values between strobes; only o_SPI_flag and o_frame_error pulse.
- Latency: o_SPI_flag rises exactly SYNC_STAGES + 2 i_clk cycles after the 56th SCK rising edge appears at the pin (4 cycles at default).
- CS rise and the 56th sck_rise in the same cycle: the frame counts as complete and is accepted.
- CS fall while in WAIT_CS or CHECK cannot occur before a CS rise; a new frame requires CS high for at least 1 synced cycle.
- At most one strobe per frame. Back-to-back frames with CS high for 2 i_clk cycles must both be delivered.

Decomposition:
- Package spi_note_pkg: CMD_NOTE_ON and CMD_NOTE_OFF defaults, FRAME_BITS = 56, byte offsets of each field, FSM state encoding (IDLE, RECEIVE, CHECK, WAIT_CS).
- Sub-module spi_pin_sync: parameterised multi-bit synchronizer with rising/falling edge outputs, instantiated once for {sck, mosi, cs_n}.

Test Plan:
- Note-on frame 90 05 01 31 2D 00 64 at SCK = i_clk/8 -> one o_SPI_flag pulse 4 cycles after the last SCK edge, with note_status=1, voice_index=5, tuning_code=32'h01312D00 (20,000,000), velocity=8'h64; o_frame_error stays 0.
- Note-off frame 80 01 03 93 87 00 00 immediately after the first (CS high for 2 cycles) -> second flag pulse with note_status=0, voice_index=1, tuning_code=32'h03938700 (60,000,000), velocity=0.
- CS raised after 30 bits -> o_frame_error pulses once, no o_SPI_flag, and the fields keep the previous values.
- Command byte A0, or voice index 8'hC8 with VOICE_COUNT=16 -> o_frame_error pulses once, no flag.
- 64 SCK edges in one CS window carrying a valid 56-bit frame -> exactly one flag; the trailing 8 bits are ignored with no error.
- i_reset asserted for 1 cycle after 20 bits of a frame, SCK continuing until CS rises -> no flag and no error; all outputs 0; the next full frame is received correctly.

Source files
------------

// File: rtl/spi_note_pkg.sv
// rtl/spi_note_pkg.sv - shared constants and FSM encoding for the SPI note receiver
package spi_note_pkg;

  localparam logic [7:0] DEFAULT_CMD_NOTE_ON  = 8'h90;
  localparam logic [7:0] DEFAULT_CMD_NOTE_OFF = 8'h80;

  localparam int FRAME_BITS = 56;

  // Bit offsets of each field inside the 56-bit frame (byte0 lands in the top byte)
  localparam int CMD_LSB      = 48;
  localparam int VOICE_LSB    = 40;
  localparam int TUNING_LSB   = 8;
  localparam int VELOCITY_LSB = 0;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RECEIVE = 2'd1,
    CHECK   = 2'd2,
    WAIT_CS = 2'd3
  } state_t;

endpackage

// File: rtl/spi_pin_sync.sv
// rtl/spi_pin_sync.sv - multi-bit pin synchronizer with rising/falling edge detect
module spi_pin_sync #(
  parameter int WIDTH  = 1,
  parameter int STAGES = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] pins,
  output logic [WIDTH-1:0] synced,
  output logic [WIDTH-1:0] rise,
  output logic [WIDTH-1:0] fall
);

  logic [WIDTH-1:0] chain [STAGES];
  logic [WIDTH-1:0] prev;

  // Reset clears to 0 so a CS held low across reset never looks like a new falling edge
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < STAGES; i++) chain[i] <= '0;
      prev <= '0;
    end else begin
      chain[0] <= pins;
      for (int i = 1; i < STAGES; i++) chain[i] <= chain[i-1];
      prev <= chain[STAGES-1];
    end
  end

  assign synced = chain[STAGES-1];
  assign rise   = synced & ~prev;
  assign fall   = ~synced & prev;

endmodule

// File: rtl/spi_note_receiver.sv
// rtl/spi_note_receiver.sv - SPI mode-0 slave turning 7-byte note frames into a note strobe
module spi_note_receiver
  import spi_note_pkg::*;
#(
  parameter int         SYNC_STAGES  = 2,
  parameter int         VOICE_COUNT  = 16,
  parameter logic [7:0] CMD_NOTE_ON  = DEFAULT_CMD_NOTE_ON,
  parameter logic [7:0] CMD_NOTE_OFF = DEFAULT_CMD_NOTE_OFF
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_sck,
  input  logic        i_mosi,
  input  logic        i_cs_n,
  output logic        o_SPI_flag,
  output logic        o_SPI_note_status,
  output logic [7:0]  o_SPI_voice_index,
  output logic [31:0] o_SPI_tuning_code,
  output logic [7:0]  o_SPI_velocity,
  output logic        o_frame_error
);

  localparam logic [5:0] LAST_BIT    = 6'(FRAME_BITS - 1);
  localparam logic [8:0] VOICE_LIMIT = 9'(VOICE_COUNT);

  logic [2:0] pin_synced, pin_rise, pin_fall;

  spi_pin_sync #(.WIDTH(3), .STAGES(SYNC_STAGES)) u_pin_sync (
    .clk    (i_clk),
    .reset  (i_reset),
    .pins   ({i_sck, i_mosi, i_cs_n}),
    .synced (pin_synced),
    .rise   (pin_rise),
    .fall   (pin_fall)
  );

  logic sck_rise, mosi, cs_high, cs_rise, cs_fall;
  assign sck_rise = pin_rise[2];
  assign mosi     = pin_synced[1];
  assign cs_high  = pin_synced[0];
  assign cs_rise  = pin_rise[0];
  assign cs_fall  = pin_fall[0];

  logic unused_edges;
  assign unused_edges = ^{pin_rise[1], pin_fall[2:1], pin_synced[2]};

  state_t                state;
  logic [FRAME_BITS-1:0] shreg;
  logic [5:0]            bit_count;

  logic [7:0] cmd, voice;
  logic       frame_ok;
  assign cmd      = shreg[CMD_LSB +: 8];
  assign voice    = shreg[VOICE_LSB +: 8];
  assign frame_ok = ((cmd == CMD_NOTE_ON) || (cmd == CMD_NOTE_OFF)) && ({1'b0, voice} < VOICE_LIMIT);

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state             <= IDLE;
      shreg             <= '0;
      bit_count         <= '0;
      o_SPI_flag        <= 1'b0;
      o_frame_error     <= 1'b0;
      o_SPI_note_status <= 1'b0;
      o_SPI_voice_index <= '0;
      o_SPI_tuning_code <= '0;
      o_SPI_velocity    <= '0;
    end else begin
      o_SPI_flag    <= 1'b0;
      o_frame_error <= 1'b0;
      case (state)
        IDLE: begin
          if (cs_fall) begin
            bit_count <= '0;
            state     <= RECEIVE;
          end
        end
        RECEIVE: begin
          // The final bit wins over a simultaneous CS rise: the frame is complete
          if (sck_rise && bit_count == LAST_BIT) begin
            shreg <= {shreg[FRAME_BITS-2:0], mosi};
            state <= CHECK;
          end else if (cs_rise) begin
            o_frame_error <= 1'b1;
            state         <= IDLE;
          end else if (sck_rise) begin
            shreg     <= {shreg[FRAME_BITS-2:0], mosi};
            bit_count <= bit_count + 6'd1;
          end
        end
        CHECK: begin
          if (frame_ok) begin
            o_SPI_flag        <= 1'b1;
            o_SPI_note_status <= (cmd == CMD_NOTE_ON);
            o_SPI_voice_index <= voice;
            o_SPI_tuning_code <= shreg[TUNING_LSB +: 32];
            o_SPI_velocity    <= {1'b0, shreg[VELOCITY_LSB +: 7]};
          end else begin
            o_frame_error <= 1'b1;
          end
          state <= WAIT_CS;
        end
        WAIT_CS: begin
          // Level test so a CS rise that coincided with the last bit is not missed
          if (cs_high) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_note_receiver.sv
// tb/tb_spi_note_receiver.sv - self-checking bench for spi_note_receiver
module tb_spi_note_receiver;

  logic        clk = 1'b0;
  logic        i_reset, i_sck, i_mosi, i_cs_n;
  logic        o_SPI_flag, o_SPI_note_status, o_frame_error;
  logic [7:0]  o_SPI_voice_index, o_SPI_velocity;
  logic [31:0] o_SPI_tuning_code;

  always #5 clk = ~clk;

  spi_note_receiver dut (
    .i_clk             (clk),
    .i_reset           (i_reset),
    .i_sck             (i_sck),
    .i_mosi            (i_mosi),
    .i_cs_n            (i_cs_n),
    .o_SPI_flag        (o_SPI_flag),
    .o_SPI_note_status (o_SPI_note_status),
    .o_SPI_voice_index (o_SPI_voice_index),
    .o_SPI_tuning_code (o_SPI_tuning_code),
    .o_SPI_velocity    (o_SPI_velocity),
    .o_frame_error     (o_frame_error)
  );

  typedef struct {
    int          cyc;
    bit          is_flag;
    logic [48:0] fields;
  } ev_t;

  ev_t         expq[$];
  logic [48:0] held = '0;
  int          checks = 0, errors = 0;
  int          cyc = 0;
  int          flag_cnt = 0, err_cnt = 0;
  bit          check_en = 0;
  logic        rst_seen = 1'b0;

  always @(posedge clk) begin
    cyc      <= cyc + 1;
    rst_seen <= i_reset;
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, exp, cyc);
    end
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Decide from the frame contents what the receiver must report, and when
  task automatic model_frame(input logic [55:0] f, input int due);
    ev_t        ev;
    logic [7:0] c, v;
    c = f[55:48];
    v = f[47:40];
    ev.cyc     = due;
    ev.is_flag = (c == 8'h90 || c == 8'h80) && (v < 8'd16);
    ev.fields  = {c == 8'h90, v, f[39:8], 1'b0, f[6:0]};
    expq.push_back(ev);
  endtask

  task automatic push_error(input int due);
    ev_t ev;
    ev.cyc     = due;
    ev.is_flag = 1'b0;
    ev.fields  = '0;
    expq.push_back(ev);
  endtask

  task automatic send_frame(input logic [63:0] data, input int nbits, input int gap,
                            input int rst_bit, input bit cs_with_last);
    bit abandon = 0;
    i_cs_n = 1'b0;
    for (int i = 0; i < nbits; i++) begin
      i_sck  = 1'b0;
      i_mosi = data[63-i];
      wait_cyc(4);
      i_sck = 1'b1;
      if (cs_with_last && i == nbits - 1) i_cs_n = 1'b1;
      if (i == 55 && !abandon) model_frame(data[63:8], cyc + 4);
      if (i == rst_bit) begin
        i_reset = 1'b1;
        wait_cyc(1);
        i_reset = 1'b0;
        abandon = 1;
        wait_cyc(3);
      end else begin
        wait_cyc(4);
      end
    end
    i_sck = 1'b0;
    wait_cyc(2);
    if (!cs_with_last) begin
      i_cs_n = 1'b1;
      if (nbits < 56 && !abandon) push_error(cyc + 3);
    end
    wait_cyc(gap);
  endtask

  // Every cycle: strobes only where the model expects them, fields hold the last valid frame
  always @(negedge clk) begin
    if (check_en) begin
      logic exp_flag, exp_err;
      if (rst_seen) begin
        expq.delete();
        held = '0;
      end
      exp_flag = 1'b0;
      exp_err  = 1'b0;
      if (expq.size() > 0 && expq[0].cyc == cyc) begin
        ev_t ev;
        ev = expq.pop_front();
        exp_flag = ev.is_flag;
        exp_err  = !ev.is_flag;
        if (ev.is_flag) held = ev.fields;
      end
      check("flag", 64'(o_SPI_flag), 64'(exp_flag));
      check("frame_error", 64'(o_frame_error), 64'(exp_err));
      check("fields", 64'({o_SPI_note_status, o_SPI_voice_index, o_SPI_tuning_code, o_SPI_velocity}),
            64'(held));
      flag_cnt += int'(o_SPI_flag);
      err_cnt  += int'(o_frame_error);
    end
  end

  localparam logic [63:0] F_ON   = 64'h9005_0131_2D00_6400;
  localparam logic [63:0] F_OFF  = 64'h8001_0393_8700_0000;
  localparam logic [63:0] F_BADC = 64'hA005_0131_2D00_6400;
  localparam logic [63:0] F_BADV = 64'h90C8_0131_2D00_6400;
  localparam logic [63:0] F_LONG = 64'h9003_0000_1000_FFAB;

  initial begin
    i_reset = 1'b1;
    i_sck   = 1'b0;
    i_mosi  = 1'b0;
    i_cs_n  = 1'b1;
    wait_cyc(4);
    i_reset = 1'b0;
    wait_cyc(4);
    check("reset_flag", 64'(o_SPI_flag), 64'd0);
    check("reset_error", 64'(o_frame_error), 64'd0);
    check("reset_fields", 64'({o_SPI_note_status, o_SPI_voice_index, o_SPI_tuning_code, o_SPI_velocity}), 64'd0);
    check_en = 1;

    send_frame(F_ON, 56, 2, -1, 0);
    check("on_count", 64'(flag_cnt), 64'd1);
    check("on_status", 64'(o_SPI_note_status), 64'd1);
    check("on_voice", 64'(o_SPI_voice_index), 64'd5);
    check("on_tuning", 64'(o_SPI_tuning_code), 64'd20000000);
    check("on_velocity", 64'(o_SPI_velocity), 64'h64);

    send_frame(F_OFF, 56, 6, -1, 0);
    check("off_count", 64'(flag_cnt), 64'd2);
    check("off_status", 64'(o_SPI_note_status), 64'd0);
    check("off_voice", 64'(o_SPI_voice_index), 64'd1);
    check("off_tuning", 64'(o_SPI_tuning_code), 64'd60000000);
    check("off_velocity", 64'(o_SPI_velocity), 64'd0);

    send_frame(F_ON, 30, 6, -1, 0);
    check("short_errors", 64'(err_cnt), 64'd1);
    check("short_flags", 64'(flag_cnt), 64'd2);
    check("short_tuning_held", 64'(o_SPI_tuning_code), 64'h0393_8700);

    send_frame(F_BADC, 56, 6, -1, 0);
    send_frame(F_BADV, 56, 6, -1, 0);
    check("bad_errors", 64'(err_cnt), 64'd3);
    check("bad_flags", 64'(flag_cnt), 64'd2);

    send_frame(F_LONG, 64, 6, -1, 0);
    check("long_flags", 64'(flag_cnt), 64'd3);
    check("long_errors", 64'(err_cnt), 64'd3);
    check("long_voice", 64'(o_SPI_voice_index), 64'd3);
    check("long_tuning", 64'(o_SPI_tuning_code), 64'h0000_1000);
    check("long_velocity", 64'(o_SPI_velocity), 64'h7F);

    send_frame(F_ON, 56, 6, 20, 0);
    check("rst_flags", 64'(flag_cnt), 64'd3);
    check("rst_errors", 64'(err_cnt), 64'd3);
    check("rst_fields", 64'({o_SPI_note_status, o_SPI_voice_index, o_SPI_tuning_code, o_SPI_velocity}), 64'd0);

    send_frame(F_ON, 56, 2, -1, 0);
    check("after_rst_flags", 64'(flag_cnt), 64'd4);
    check("after_rst_voice", 64'(o_SPI_voice_index), 64'd5);

    send_frame(F_OFF, 56, 2, -1, 1);
    check("cs_last_flags", 64'(flag_cnt), 64'd5);
    check("cs_last_status", 64'(o_SPI_note_status), 64'd0);

    send_frame(F_ON, 56, 6, -1, 0);
    check("final_flags", 64'(flag_cnt), 64'd6);
    check("final_errors", 64'(err_cnt), 64'd3);
    check("pending_events", 64'(expq.size()), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
